// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared constants and grant encoding for the register-file write-back path
package regfile_ctrl_pkg;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] REG_X0 = '0;

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_MCU = 1'b1
   } grant_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter between the ALU and MCU write requesters
module rr_arbiter2
   import regfile_ctrl_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_alu_i,
   input  logic req_mcu_i,
   output logic gnt_alu_o,
   output logic gnt_mcu_o
);
   grant_e last_q, last_d;

   // On a tie the requester that did not win last time gets the port.
   always_comb begin
      gnt_alu_o = req_alu_i && (!req_mcu_i || (last_q == GNT_MCU));
      gnt_mcu_o = req_mcu_i && (!req_alu_i || (last_q == GNT_ALU));
      last_d    = last_q;
      if (gnt_alu_o) begin
         last_d = GNT_ALU;
      end else if (gnt_mcu_o) begin
         last_d = GNT_MCU;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= GNT_MCU;
      end else begin
         last_q <= last_d;
      end
   end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register-file write-port arbitration, busy scoreboard and decode stall
module regfile_wb_scheduler
   import regfile_ctrl_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [ADDR_W-1:0]   rs1addr_i,
   input  logic [ADDR_W-1:0]   rs2addr_i,
   input  logic                issue_valid_i,
   input  logic [ADDR_W-1:0]   issue_rd_i,
   output logic                stall_o,
   input  logic                alu_valid_i,
   output logic                alu_ready_o,
   input  logic [ADDR_W-1:0]   alu_rd_i,
   input  logic [DATA_W-1:0]   alu_data_i,
   input  logic                mcu_valid_i,
   output logic                mcu_ready_o,
   input  logic [ADDR_W-1:0]   mcu_rd_i,
   input  logic [DATA_W-1:0]   mcu_data_i,
   output logic                RegWrite_o,
   output logic [ADDR_W-1:0]   RDaddr_o,
   output logic [DATA_W-1:0]   RDdata_o,
   output logic [NUM_REGS-1:0] busy_o,
   output logic                error_o
);
   logic                gnt_alu, gnt_mcu;
   logic                regwrite_q;
   logic [ADDR_W-1:0]   rdaddr_q;
   logic [DATA_W-1:0]   rddata_q;
   grant_e              src_q;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                error_q, error_d;
   logic                raw_busy, raw_inflight, waw;

   rr_arbiter2 u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_alu_i (alu_valid_i),
      .req_mcu_i (mcu_valid_i),
      .gnt_alu_o (gnt_alu),
      .gnt_mcu_o (gnt_mcu)
   );

   assign alu_ready_o = gnt_alu;
   assign mcu_ready_o = gnt_mcu;

   assign raw_busy     = ((rs1addr_i != REG_X0) && busy_q[rs1addr_i]) ||
                         ((rs2addr_i != REG_X0) && busy_q[rs2addr_i]);
   // The output-stage write is only visible in the register file after this cycle.
   assign raw_inflight = regwrite_q && (rdaddr_q != REG_X0) &&
                         ((rdaddr_q == rs1addr_i) || (rdaddr_q == rs2addr_i));
   assign waw          = issue_valid_i && busy_q[issue_rd_i];
   assign stall_o      = raw_busy || raw_inflight || waw;

   // Clear first so a same-cycle reservation of the same register survives.
   always_comb begin
      busy_d = busy_q;
      if (regwrite_q && (src_q == GNT_MCU)) begin
         busy_d[rdaddr_q] = 1'b0;
      end
      if (issue_valid_i && !stall_o && (issue_rd_i != REG_X0)) begin
         busy_d[issue_rd_i] = 1'b1;
      end
      error_d = error_q;
      if (gnt_alu && busy_q[alu_rd_i]) begin
         error_d = 1'b1;
      end
      if (gnt_mcu && (mcu_rd_i != REG_X0) && !busy_q[mcu_rd_i]) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regwrite_q <= 1'b0;
         rdaddr_q   <= '0;
         rddata_q   <= '0;
         src_q      <= GNT_ALU;
         busy_q     <= '0;
         error_q    <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         error_q <= error_d;
         if (gnt_alu) begin
            regwrite_q <= (alu_rd_i != REG_X0);
            rdaddr_q   <= alu_rd_i;
            rddata_q   <= alu_data_i;
            src_q      <= GNT_ALU;
         end else if (gnt_mcu) begin
            regwrite_q <= (mcu_rd_i != REG_X0);
            rdaddr_q   <= mcu_rd_i;
            rddata_q   <= mcu_data_i;
            src_q      <= GNT_MCU;
         end else begin
            regwrite_q <= 1'b0;
         end
      end
   end

   assign RegWrite_o = regwrite_q;
   assign RDaddr_o   = rdaddr_q;
   assign RDdata_o   = rddata_q;
   assign busy_o     = busy_q;
   assign error_o    = error_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed vector table plus randomized model comparison for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
   import regfile_ctrl_pkg::*;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic [ADDR_W-1:0]   rs1addr_i, rs2addr_i, issue_rd_i, alu_rd_i, mcu_rd_i;
   logic                issue_valid_i, alu_valid_i, mcu_valid_i;
   logic [DATA_W-1:0]   alu_data_i, mcu_data_i;
   logic                stall_o, alu_ready_o, mcu_ready_o, RegWrite_o, error_o;
   logic [ADDR_W-1:0]   RDaddr_o;
   logic [DATA_W-1:0]   RDdata_o;
   logic [NUM_REGS-1:0] busy_o;

   regfile_wb_scheduler dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rs1addr_i(rs1addr_i), .rs2addr_i(rs2addr_i),
      .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .stall_o(stall_o),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
      .mcu_valid_i(mcu_valid_i), .mcu_ready_o(mcu_ready_o), .mcu_rd_i(mcu_rd_i), .mcu_data_i(mcu_data_i),
      .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
      .busy_o(busy_o), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic [4:0]  rs1, rs2;
      logic        iv;
      logic [4:0]  ird;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] md;
      logic        e_ar, e_mr, e_st, e_we, e_chk_ad;
      logic [4:0]  e_addr;
      logic [31:0] e_data, e_busy;
      logic        e_err;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl [23];

   // Reference state: what the spec says the block should hold after each cycle.
   bit          m_busy [32];
   bit          m_last_mcu, m_we, m_src_mcu, m_err;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v);
      rst_i = v.rst; rs1addr_i = v.rs1; rs2addr_i = v.rs2;
      issue_valid_i = v.iv; issue_rd_i = v.ird;
      alu_valid_i = v.av; alu_rd_i = v.ard; alu_data_i = v.ad;
      mcu_valid_i = v.mv; mcu_rd_i = v.mrd; mcu_data_i = v.md;
      #4;
      chk("alu_ready", {31'b0, alu_ready_o}, {31'b0, v.e_ar});
      chk("mcu_ready", {31'b0, mcu_ready_o}, {31'b0, v.e_mr});
      chk("stall", {31'b0, stall_o}, {31'b0, v.e_st});
      @(posedge clk_i);
      #1;
      chk("RegWrite", {31'b0, RegWrite_o}, {31'b0, v.e_we});
      if (v.e_chk_ad) begin
         chk("RDaddr", {27'b0, RDaddr_o}, {27'b0, v.e_addr});
         chk("RDdata", RDdata_o, v.e_data);
      end
      chk("busy", busy_o, v.e_busy);
      chk("error", {31'b0, error_o}, {31'b0, v.e_err});
   endtask

   task automatic model_fill(inout vec_t v);
      bit hs_a, hs_m, st;
      if (v.av && v.mv) begin
         v.e_ar = m_last_mcu;
         v.e_mr = !m_last_mcu;
      end else begin
         v.e_ar = v.av;
         v.e_mr = v.mv;
      end
      st = 1'b0;
      if (v.rs1 != 0 && m_busy[v.rs1]) st = 1'b1;
      if (v.rs2 != 0 && m_busy[v.rs2]) st = 1'b1;
      if (m_we && m_addr != 0 && (m_addr == v.rs1 || m_addr == v.rs2)) st = 1'b1;
      if (v.iv && m_busy[v.ird]) st = 1'b1;
      v.e_st = st;
      hs_a = v.av && v.e_ar;
      hs_m = v.mv && v.e_mr;
      if (v.rst) begin
         for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
         m_last_mcu = 1'b1; m_we = 1'b0; m_src_mcu = 1'b0; m_err = 1'b0;
         m_addr = '0; m_data = '0;
      end else begin
         if (hs_a && m_busy[v.ard]) m_err = 1'b1;
         if (hs_m && v.mrd != 0 && !m_busy[v.mrd]) m_err = 1'b1;
         if (m_we && m_src_mcu) m_busy[m_addr] = 1'b0;
         if (v.iv && !st && v.ird != 0) m_busy[v.ird] = 1'b1;
         if (hs_a) begin
            m_last_mcu = 1'b0; m_we = (v.ard != 0); m_addr = v.ard; m_data = v.ad; m_src_mcu = 1'b0;
         end else if (hs_m) begin
            m_last_mcu = 1'b1; m_we = (v.mrd != 0); m_addr = v.mrd; m_data = v.md; m_src_mcu = 1'b1;
         end else begin
            m_we = 1'b0;
         end
      end
      v.e_we = m_we;
      v.e_chk_ad = m_we || v.rst;
      v.e_addr = m_addr;
      v.e_data = m_data;
      v.e_err = m_err;
      for (int r = 0; r < 32; r++) v.e_busy[r] = m_busy[r];
   endtask

   initial begin
      vec_t v;
      // rst rs1 rs2 iv ird av ard ad mv mrd md | ar mr st we chk addr data busy err
      tbl[0]  = '{1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 32'h0, 0};
      tbl[1]  = '{0, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 32'h0, 0};
      tbl[2]  = '{0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h4, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22,  1, 0, 0, 1, 1, 1, 32'h11, 32'h4, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22,  0, 1, 0, 1, 1, 2, 32'h22, 32'h4, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22,  1, 0, 0, 1, 1, 1, 32'h11, 32'h0, 0};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h0, 0};
      tbl[7]  = '{0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 1, 1, 7, 32'hDEADBEEF, 32'h0, 0};
      tbl[8]  = '{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 1, 7, 32'hDEADBEEF, 32'h0, 0};
      tbl[9]  = '{0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h0, 0};
      tbl[10] = '{0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h200, 0};
      tbl[11] = '{0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h200, 0};
      tbl[12] = '{0, 9, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99,       0, 1, 1, 1, 1, 9, 32'h99, 32'h200, 0};
      tbl[13] = '{0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h0, 0};
      tbl[14] = '{0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h0, 0};
      tbl[15] = '{0, 0, 0, 0, 0, 1, 0, 32'h5, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0, 32'h0, 0};
      tbl[16] = '{0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h200, 0};
      tbl[17] = '{0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0, 0, 32'h200, 0};
      tbl[18] = '{0, 0, 0, 0, 0, 1, 9, 32'h1, 0, 0, 0,        1, 0, 0, 1, 1, 9, 32'h1, 32'h200, 1};
      tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h200, 1};
      tbl[20] = '{0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 32'h208, 1};
      tbl[21] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33,       0, 1, 0, 0, 1, 0, 0, 32'h0, 0};
      tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 32'h0, 0};

      rst_i = 1'b1; rs1addr_i = '0; rs2addr_i = '0; issue_valid_i = 1'b0; issue_rd_i = '0;
      alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
      mcu_valid_i = 1'b0; mcu_rd_i = '0; mcu_data_i = '0;
      repeat (2) @(posedge clk_i);
      #1;

      for (int i = 0; i < 23; i++) run_vec(tbl[i]);

      for (int i = 0; i < 400; i++) begin
         v.rst = (i == 0) || ($urandom_range(0, 39) == 0);
         v.rs1 = 5'($urandom_range(0, 7));
         v.rs2 = 5'($urandom_range(0, 7));
         v.iv  = $urandom_range(0, 2) == 0;
         v.ird = 5'($urandom_range(0, 7));
         v.av  = $urandom_range(0, 1) == 1;
         v.ard = 5'($urandom_range(0, 7));
         v.ad  = $urandom;
         v.mv  = $urandom_range(0, 2) == 0;
         v.mrd = 5'($urandom_range(0, 7));
         v.md  = $urandom;
         model_fill(v);
         run_vec(v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
